// File: rtl/query_row_dbuf_pkg.sv
// Shared defaults for the query-row ping-pong buffer.
package query_row_dbuf_pkg;
    localparam int QRD_DATA_WIDTH = 11;
    localparam int QRD_ADDR_WIDTH = 7;
    localparam int QRD_DEPTH      = 128;
endpackage

// File: rtl/query_row_bank.sv
// One row of storage: simple dual-port RAM, one write port, registered read-first read port.
module query_row_bank
    import query_row_dbuf_pkg::*;
#(
    parameter int DATA_WIDTH = QRD_DATA_WIDTH,
    parameter int ADDR_WIDTH = QRD_ADDR_WIDTH,
    parameter int DEPTH      = QRD_DEPTH
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Both statements sample mem before the edge, so a colliding read sees the old word.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/query_row_dbuf.sv
// Ping-pong row buffer: sequential writer fills one bank while the reader fetches by address from the other.
module query_row_dbuf
    import query_row_dbuf_pkg::*;
#(
    parameter int DATA_WIDTH = QRD_DATA_WIDTH,
    parameter int ADDR_WIDTH = QRD_ADDR_WIDTH,
    parameter int DEPTH      = QRD_DEPTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  fsm_enable,
    input  logic                  sender_enable,
    input  logic [DATA_WIDTH-1:0] sender_data,
    input  logic                  ren,
    input  logic [ADDR_WIDTH-1:0] radr,
    output logic [DATA_WIDTH-1:0] receiver_data
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [ADDR_WIDTH:0]   DEPTH_X   = (ADDR_WIDTH + 1)'(DEPTH);

    logic                  wbank;
    logic [ADDR_WIDTH-1:0] waddr;
    logic                  rbank;
    logic                  rsel_q;   // bank that produced the data currently held
    logic                  zero_q;   // forces output to 0 after reset or out-of-range read
    logic                  wr_en;
    logic                  rd_in_range;
    logic                  rd_go;
    logic [DATA_WIDTH-1:0] bank_q [2];

    assign wr_en       = rst_n && fsm_enable && sender_enable;
    assign rd_in_range = {1'b0, radr} < DEPTH_X;
    assign rd_go       = rst_n && ren && rd_in_range;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wbank  <= 1'b0;
            waddr  <= '0;
            rbank  <= 1'b0;
            rsel_q <= 1'b0;
            zero_q <= 1'b1;
        end else begin
            if (fsm_enable && sender_enable) begin
                if (waddr == LAST_ADDR) begin
                    waddr <= '0;
                    wbank <= ~wbank;
                end else begin
                    waddr <= waddr + 1'b1;
                end
            end
            if (ren) begin
                zero_q <= !rd_in_range;
                if (rd_in_range) begin
                    rsel_q <= rbank;
                    if (radr == LAST_ADDR) rbank <= ~rbank;
                end
            end
        end
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        query_row_bank #(
            .DATA_WIDTH (DATA_WIDTH),
            .ADDR_WIDTH (ADDR_WIDTH),
            .DEPTH      (DEPTH)
        ) u_bank (
            .clk   (clk),
            .we    (wr_en && (wbank == 1'(b))),
            .waddr (waddr),
            .wdata (sender_data),
            .re    (rd_go && (rbank == 1'(b))),
            .raddr (radr),
            .rdata (bank_q[b])
        );
    end

    // Each bank's read register only loads when read, so the selected one holds while ren is low.
    assign receiver_data = zero_q ? '0 : bank_q[rsel_q];

endmodule

// File: tb/tb_query_row_dbuf.sv
// Directed checks for query_row_dbuf: default geometry plus a DEPTH=100 / ADDR_WIDTH=8 instance.
module tb_query_row_dbuf;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fsm_enable = 1'b0;
    logic        sender_enable = 1'b0;
    logic [10:0] sender_data = '0;
    logic        ren = 1'b0;
    logic [6:0]  radr = '0;
    logic [10:0] receiver_data;

    logic        rst2_n = 1'b0;
    logic        fsm2 = 1'b0;
    logic        sen2 = 1'b0;
    logic [10:0] data2 = '0;
    logic        ren2 = 1'b0;
    logic [7:0]  radr2 = '0;
    logic [10:0] rdata2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    query_row_dbuf dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .fsm_enable    (fsm_enable),
        .sender_enable (sender_enable),
        .sender_data   (sender_data),
        .ren           (ren),
        .radr          (radr),
        .receiver_data (receiver_data)
    );

    query_row_dbuf #(.DATA_WIDTH(11), .ADDR_WIDTH(8), .DEPTH(100)) dut2 (
        .clk           (clk),
        .rst_n         (rst2_n),
        .fsm_enable    (fsm2),
        .sender_enable (sen2),
        .sender_data   (data2),
        .ren           (ren2),
        .radr          (radr2),
        .receiver_data (rdata2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; fsm_enable = 1'b0; sender_enable = 1'b0; ren = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
    endtask

    task automatic wr(input logic [10:0] d);
        fsm_enable = 1'b1; sender_enable = 1'b1; sender_data = d;
        tick();
        sender_enable = 1'b0;
    endtask

    task automatic rd(input logic [6:0] a);
        ren = 1'b1; radr = a;
        tick();
        ren = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; fsm_enable = 1'b1; sender_enable = 1'b1;
        sender_data = 11'h123; ren = 1'b1; radr = 7'd0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (receiver_data !== 11'h000) begin
                errors++;
                $display("FAIL reset_out cyc%0d got %h want 000", i, receiver_data);
            end
        end
        rst_n = 1'b1; sender_enable = 1'b0; ren = 1'b0;
        tick();
        wr(11'h02A);
        rd(7'd0);
        checks++;
        if (receiver_data !== 11'h02A) begin
            errors++;
            $display("FAIL reset_first_write got %h want 02a", receiver_data);
        end
        // addr 1 would hold 0x123 had the writes during reset landed
        rd(7'd1);
        checks++;
        if (receiver_data === 11'h123) begin
            errors++;
            $display("FAIL reset_no_write got %h want not 123", receiver_data);
        end
    endtask

    task automatic test_stream();
        do_reset();
        for (int n = 0; n < 10; n++) begin
            wr(11'(n));
            tick();
            rd(7'(n));
            checks++;
            if (receiver_data !== 11'(n)) begin
                errors++;
                $display("FAIL stream addr%0d got %0d want %0d", n, receiver_data, n);
            end
        end
    endtask

    task automatic test_gate();
        do_reset();
        fsm_enable = 1'b0; sender_enable = 1'b1; sender_data = 11'h7FF;
        for (int i = 0; i < 5; i++) tick();
        fsm_enable = 1'b1; sender_data = 11'd5;
        tick();
        sender_enable = 1'b0; fsm_enable = 1'b0;
        rd(7'd0);
        checks++;
        if (receiver_data !== 11'd5) begin
            errors++;
            $display("FAIL gate_addr0 got %0d want 5", receiver_data);
        end
        // addr 5 keeps the value from the stream test
        rd(7'd5);
        checks++;
        if (receiver_data !== 11'd5) begin
            errors++;
            $display("FAIL gate_addr5 got %0d want 5", receiver_data);
        end
    endtask

    task automatic test_bank_swap();
        int bad;
        do_reset();
        fsm_enable = 1'b1; sender_enable = 1'b1;
        for (int i = 0; i < 256; i++) begin
            sender_data = (i < 128) ? 11'(i) : 11'(1000 + i - 128);
            tick();
        end
        sender_enable = 1'b0;
        bad = 0;
        ren = 1'b1;
        for (int i = 0; i < 128; i++) begin
            radr = 7'(i);
            tick();
            checks++;
            if (receiver_data !== 11'(i)) begin
                errors++;
                bad++;
                if (bad < 5) $display("FAIL swap_bank0 addr%0d got %0d want %0d", i, receiver_data, i);
            end
        end
        radr = 7'd0;
        tick();
        checks++;
        if (receiver_data !== 11'd1000) begin
            errors++;
            $display("FAIL swap_bank1_first got %0d want 1000", receiver_data);
        end
        radr = 7'd127;
        tick();
        checks++;
        if (receiver_data !== 11'd1127) begin
            errors++;
            $display("FAIL swap_bank1_last got %0d want 1127", receiver_data);
        end
        radr = 7'd0;
        tick();
        ren = 1'b0;
        checks++;
        if (receiver_data !== 11'd0) begin
            errors++;
            $display("FAIL swap_back_bank0 got %0d want 0", receiver_data);
        end
    endtask

    task automatic test_collision();
        do_reset();
        // bank0 addr 3 still holds 3 from the bank-swap fill
        wr(11'd0); wr(11'd1); wr(11'd2);
        fsm_enable = 1'b1; sender_enable = 1'b1; sender_data = 11'h555;
        ren = 1'b1; radr = 7'd3;
        tick();
        sender_enable = 1'b0; ren = 1'b0;
        checks++;
        if (receiver_data !== 11'd3) begin
            errors++;
            $display("FAIL collide_old got %h want 003", receiver_data);
        end
        rd(7'd3);
        checks++;
        if (receiver_data !== 11'h555) begin
            errors++;
            $display("FAIL collide_new got %h want 555", receiver_data);
        end
    endtask

    task automatic test_hold();
        ren = 1'b0;
        for (int i = 0; i < 4; i++) begin
            radr = 7'($urandom_range(0, 127));
            wr(11'(i + 40));
            checks++;
            if (receiver_data !== 11'h555) begin
                errors++;
                $display("FAIL hold cyc%0d got %h want 555", i, receiver_data);
            end
        end
    endtask

    task automatic test_out_of_range();
        rst2_n = 1'b0;
        tick(); tick();
        rst2_n = 1'b1;
        fsm2 = 1'b1; sen2 = 1'b1;
        for (int i = 0; i < 200; i++) begin
            data2 = (i < 100) ? 11'(200 + i) : 11'(500 + i - 100);
            tick();
        end
        sen2 = 1'b0;
        ren2 = 1'b1; radr2 = 8'd5;
        tick();
        checks++;
        if (rdata2 !== 11'd205) begin
            errors++;
            $display("FAIL oor_pre got %0d want 205", rdata2);
        end
        radr2 = 8'd128;
        tick();
        checks++;
        if (rdata2 !== 11'd0) begin
            errors++;
            $display("FAIL oor_zero got %0d want 0", rdata2);
        end
        radr2 = 8'd5;
        tick();
        checks++;
        if (rdata2 !== 11'd205) begin
            errors++;
            $display("FAIL oor_no_toggle got %0d want 205", rdata2);
        end
        radr2 = 8'd99;
        tick();
        checks++;
        if (rdata2 !== 11'd299) begin
            errors++;
            $display("FAIL d100_last got %0d want 299", rdata2);
        end
        radr2 = 8'd0;
        tick();
        ren2 = 1'b0;
        checks++;
        if (rdata2 !== 11'd500) begin
            errors++;
            $display("FAIL d100_swap got %0d want 500", rdata2);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_gate();
        test_bank_swap();
        test_collision();
        test_hold();
        test_out_of_range();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
